// File: rtl/tt_sweep_checker_if.sv
// Bundle between the sweep checker and the logic netlist / controller it serves.
// The checker uses the slave side; the netlist model and control use the master side.
interface tt_sweep_checker_if;
  logic       start;
  logic       dut_out;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       done;
  logic [7:0] measured_tt;
  logic [7:0] mismatch;
  logic [3:0] err_count;
  logic       pass;

  modport master (
    output start, dut_out,
    input  in1, in2, in3, busy, done, measured_tt, mismatch, err_count, pass
  );

  modport slave (
    input  start, dut_out,
    output in1, in2, in3, busy, done, measured_tt, mismatch, err_count, pass
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// Walks all eight input rows of a 3-input netlist, samples its synchronized output
// per row, and grades the captured truth table against EXPECTED_TT.
module tt_sweep_checker #(
  parameter logic [7:0] EXPECTED_TT   = 8'hB9,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  tt_sweep_checker_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam int             CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  state_t        r_state, w_state;
  logic [2:0]    r_idx,   w_idx;
  logic [CW-1:0] r_cnt,   w_cnt;
  logic [2:0]    r_in,    w_in;
  logic [1:0]    r_sync;
  logic [7:0]    r_meas,  w_meas;
  logic [7:0]    r_mm,    w_mm;
  logic [3:0]    r_err,   w_err;
  logic          r_pass,  w_pass;
  logic          r_done,  w_done;
  logic [7:0]    w_diff;
  logic [3:0]    w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_in   <= '0;
      r_sync <= '0;
      r_meas <= '0;
      r_mm   <= '0;
      r_err  <= '0;
      r_pass <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_idx  <= w_idx;
      r_cnt  <= w_cnt;
      r_in   <= w_in;
      r_sync <= {r_sync[0], bus.dut_out};
      r_meas <= w_meas;
      r_mm   <= w_mm;
      r_err  <= w_err;
      r_pass <= w_pass;
      r_done <= w_done;
    end
  end

  always_comb begin
    w_diff = r_meas ^ EXPECTED_TT;
    w_pop  = '0;
    for (int i = 0; i < 8; i++) w_pop = w_pop + 4'(w_diff[i]);
  end

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_in    = r_in;
    w_meas  = r_meas;
    w_mm    = r_mm;
    w_err   = r_err;
    w_pass  = r_pass;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_idx   = '0;
          w_in    = '0;
          w_meas  = '0;
          w_mm    = '0;
          w_err   = '0;
          w_pass  = 1'b0;
          w_cnt   = CNT_LOAD;
          w_state = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_state = S_SAMPLE;
        else             w_cnt   = r_cnt - 1'b1;
      end
      S_SAMPLE: begin
        // Row 000 lands in bit 7, matching the EXPECTED_TT ordering.
        w_meas[3'd7 - r_idx] = r_sync[1];
        if (r_idx != 3'd7) begin
          w_idx   = r_idx + 3'd1;
          w_in    = r_idx + 3'd1;
          w_cnt   = CNT_LOAD;
          w_state = S_SETTLE;
        end else begin
          w_state = S_DONE;
        end
      end
      S_DONE: begin
        w_mm    = w_diff;
        w_err   = w_pop;
        w_pass  = (w_pop == 4'd0);
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign bus.in1         = r_in[2];
  assign bus.in2         = r_in[1];
  assign bus.in3         = r_in[0];
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.measured_tt = r_meas;
  assign bus.mismatch    = r_mm;
  assign bus.err_count   = r_err;
  assign bus.pass        = r_pass;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench: three checkers (settle 4/5/2) each driving a netlist model with
// random or fixed truth tables; the 5 and 2 instances see a 3-cycle netlist delay.
module tb_tt_sweep_checker;

  typedef struct {
    int         st;
    logic [7:0] meas;
    logic [7:0] mm;
    logic [3:0] err;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tt_sweep_checker_if b0 ();
  tt_sweep_checker_if b1 ();
  tt_sweep_checker_if b2 ();

  tt_sweep_checker                          u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  tt_sweep_checker #(.SETTLE_CYCLES(5))     u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  tt_sweep_checker #(.SETTLE_CYCLES(2))     u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  logic       go    [3];
  logic [7:0] ntt   [3];
  logic [2:0] ins   [3];
  logic       fo    [3];
  logic [2:0] dlv   [3];
  logic       done_a[3];
  logic       busy_a[3];
  logic [7:0] meas_a[3];
  logic [7:0] mm_a  [3];
  logic [3:0] err_a [3];
  logic       pass_a[3];

  assign b0.start = go[0];
  assign b1.start = go[1];
  assign b2.start = go[2];
  assign ins[0] = {b0.in1, b0.in2, b0.in3};
  assign ins[1] = {b1.in1, b1.in2, b1.in3};
  assign ins[2] = {b2.in1, b2.in2, b2.in3};

  // Netlist model: truth-table lookup, optionally behind a 3-stage delay line.
  always_comb begin
    for (int k = 0; k < 3; k++) fo[k] = ntt[k][3'd7 - ins[k]];
  end
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) dlv[k] <= {dlv[k][1:0], fo[k]};
  end
  assign b0.dut_out = fo[0];
  assign b1.dut_out = dlv[1][2];
  assign b2.dut_out = dlv[2][2];

  assign done_a[0] = b0.done;        assign done_a[1] = b1.done;        assign done_a[2] = b2.done;
  assign busy_a[0] = b0.busy;        assign busy_a[1] = b1.busy;        assign busy_a[2] = b2.busy;
  assign meas_a[0] = b0.measured_tt; assign meas_a[1] = b1.measured_tt; assign meas_a[2] = b2.measured_tt;
  assign mm_a[0]   = b0.mismatch;    assign mm_a[1]   = b1.mismatch;    assign mm_a[2]   = b2.mismatch;
  assign err_a[0]  = b0.err_count;   assign err_a[1]  = b1.err_count;   assign err_a[2]  = b2.err_count;
  assign pass_a[0] = b0.pass;        assign pass_a[1] = b1.pass;        assign pass_a[2] = b2.pass;

  exp_t       sb  [3][$];
  exp_t       last[3];
  logic [2:0] prev[3];
  int         nchk = 0;
  int         npass = 0;
  logic       mon_en = 1'b0;

  function automatic int pp(int k);
    return (k == 0) ? 5 : (k == 1) ? 6 : 3;
  endfunction

  function automatic int dly(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Reference: the value sampled for row r reflects the inputs driven
  // 3 + netlist-delay edges before its sample edge (r+1)*P.
  function automatic exp_t model(logic [7:0] tt, int p, int d, logic [2:0] pv, int st);
    exp_t e;
    int   t;
    int   row;
    e.st   = st;
    e.meas = '0;
    for (int r = 0; r < 8; r++) begin
      t   = (r + 1) * p - 3 - d;
      row = (t < 0) ? int'(pv) : ((t / p > 7) ? 7 : t / p);
      e.meas[7 - r] = tt[7 - row];
    end
    e.mm   = e.meas ^ 8'hB9;
    e.err  = 4'($countones(e.mm));
    e.pass = (e.mm == 8'h00);
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic idle_chk(int k);
    chk($sformatf("idle_busy%0d", k), 32'(busy_a[k]), 32'd0);
    chk($sformatf("idle_done%0d", k), 32'(done_a[k]), 32'd0);
    chk($sformatf("hold_meas%0d", k), 32'(meas_a[k]), 32'(last[k].meas));
    chk($sformatf("hold_mm%0d",   k), 32'(mm_a[k]),   32'(last[k].mm));
    chk($sformatf("hold_err%0d",  k), 32'(err_a[k]),  32'(last[k].err));
    chk($sformatf("hold_pass%0d", k), 32'(pass_a[k]), 32'(last[k].pass));
  endtask

  exp_t me;
  int   mkk;
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (sb[k].size() == 0) begin
          idle_chk(k);
        end else begin
          me  = sb[k][0];
          mkk = cyc - me.st;
          if (mkk < 0) begin
            idle_chk(k);
          end else if (mkk <= 8 * pp(k)) begin
            chk($sformatf("run_busy%0d", k), 32'(busy_a[k]), 32'd1);
            chk($sformatf("run_done%0d", k), 32'(done_a[k]), 32'd0);
            chk($sformatf("row_in%0d", k), 32'(ins[k]),
                32'((mkk / pp(k) > 7) ? 7 : mkk / pp(k)));
          end else begin
            chk($sformatf("done_pulse%0d", k), 32'(done_a[k]), 32'd1);
            chk($sformatf("end_busy%0d", k),   32'(busy_a[k]), 32'd0);
            chk($sformatf("meas%0d", k),       32'(meas_a[k]), 32'(me.meas));
            chk($sformatf("mismatch%0d", k),   32'(mm_a[k]),   32'(me.mm));
            chk($sformatf("err%0d", k),        32'(err_a[k]),  32'(me.err));
            chk($sformatf("pass%0d", k),       32'(pass_a[k]), 32'(me.pass));
            chk($sformatf("err_pop%0d", k),    32'(err_a[k]),  32'($countones(mm_a[k])));
            last[k] = me;
            void'(sb[k].pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tt(int k, logic [7:0] tt);
    ntt[k] = tt;
    repeat (8) tick();
  endtask

  task automatic issue(int k, output int st);
    st = cyc + 1;
    sb[k].push_back(model(ntt[k], pp(k), dly(k), prev[k], st));
    prev[k] = 3'd7;
    go[k] = 1'b1;
    tick();
    go[k] = 1'b0;
  endtask

  task automatic wait_idle(int k);
    int n;
    n = 0;
    while (sb[k].size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      nchk++;
      $display("FAIL timeout%0d: no done within %0d cycles, expected done", k, n);
      sb[k].delete();
    end
    repeat (2) tick();
  endtask

  task automatic sweep(int k, logic [7:0] tt);
    int st;
    set_tt(k, tt);
    issue(k, st);
    wait_idle(k);
  endtask

  initial begin
    int   st;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      go[k]   = 1'b0;
      ntt[k]  = 8'hB9;
      prev[k] = 3'd0;
      last[k] = '{0, 8'h00, 8'h00, 4'h0, 1'b0};
    end
    repeat (6) tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy%0d", k), 32'(busy_a[k]), 32'd0);
      chk($sformatf("rst_done%0d", k), 32'(done_a[k]), 32'd0);
      chk($sformatf("rst_in%0d", k),   32'(ins[k]),    32'd0);
      chk($sformatf("rst_meas%0d", k), 32'(meas_a[k]), 32'd0);
      chk($sformatf("rst_err%0d", k),  32'(err_a[k]),  32'd0);
      chk($sformatf("rst_pass%0d", k), 32'(pass_a[k]), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    sweep(0, 8'hB9);
    sweep(0, 8'h00);
    sweep(0, 8'h46);
    repeat (6) sweep(0, 8'($urandom));

    // start pulse during row 3 must be ignored
    set_tt(0, 8'hB9);
    issue(0, st);
    while (cyc < st + 3 * pp(0) + 2) tick();
    go[0] = 1'b1;
    tick();
    go[0] = 1'b0;
    wait_idle(0);

    // start held high re-arms right after the done cycle
    set_tt(0, 8'($urandom));
    st = cyc + 1;
    sb[0].push_back(model(ntt[0], pp(0), dly(0), prev[0], st));
    sb[0].push_back(model(ntt[0], pp(0), dly(0), 3'd7, st + 8 * pp(0) + 2));
    prev[0] = 3'd7;
    go[0] = 1'b1;
    while (cyc < st + 8 * pp(0) + 2) tick();
    go[0] = 1'b0;
    wait_idle(0);

    // one-cycle reset during row 5 aborts the sweep
    set_tt(0, 8'hB9);
    issue(0, st);
    while (cyc < st + 5 * pp(0) + 2) tick();
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      sb[k].delete();
      prev[k] = 3'd0;
      last[k] = '{0, 8'h00, 8'h00, 4'h0, 1'b0};
    end
    chk("abort_busy", 32'(busy_a[0]), 32'd0);
    chk("abort_in",   32'(ins[0]),    32'd0);
    chk("abort_meas", 32'(meas_a[0]), 32'd0);
    chk("abort_mm",   32'(mm_a[0]),   32'd0);
    chk("abort_err",  32'(err_a[0]),  32'd0);
    chk("abort_pass", 32'(pass_a[0]), 32'd0);
    rst_n = 1'b1;
    sweep(0, 8'hB9);
    chk("post_rst_pass", 32'(pass_a[0]), 32'd1);

    // delayed netlist, settle 5: enough margin
    sweep(1, 8'hB9);
    chk("s5_pass", 32'(pass_a[1]), 32'd1);
    repeat (2) sweep(1, 8'($urandom));

    // delayed netlist, settle 2: previous row leaks into each sample
    sweep(2, 8'hB9);
    chk("s2_pass", 32'(pass_a[2]), 32'd0);
    chk("s2_err_pop", 32'(err_a[2]), 32'($countones(mm_a[2])));
    repeat (2) sweep(2, 8'($urandom));

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
